sram_mem_stage: RTL and testbench

Memory-stage controller that replaces the single-cycle data memory behind the execute stage. It turns 32-bit load/store requests into two 16-bit accesses on an external SRAM. It deasserts `ready` while an access is in flight so the pipeline freezes. It delivers the 32-bit load result on `read_data` to the write-back stage.

---
 rtl/sram_mem_stage.sv | 143 ++++++++++++++
 tb/tb_sram_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage.sv
// rtl/sram_mem_stage.sv - memory stage splitting 32-bit loads/stores into two 16-bit SRAM phases
module sram_mem_stage #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [SRAM_AW-1:0] base_q, base_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    // Word-aligned halfword index inside the SRAM window; high bits wrap away.
    logic [31:0]        offset;
    logic [SRAM_AW-1:0] req_base;
    logic [SRAM_AW-1:0] base_hi;
    logic               unused_offset_bits;

    assign offset             = address - 32'(BASE_ADDR);
    assign req_base           = {offset[SRAM_AW:2], 1'b0};
    assign base_hi            = base_q + 1'b1;
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign read_data = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state_q)
            S_IDLE: begin
                ready = ~wr_en & ~rd_en;
                if (wr_en | rd_en) begin
                    op_wr_d = wr_en;
                    base_d  = req_base;
                    wdata_d = write_data;
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end

            S_LOW: begin
                sram_addr = base_q;
                if (op_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = 1'b0;
                end
                if (cnt_q == CNT_LAST) begin
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HIGH: begin
                sram_addr = base_hi;
                if (op_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = 1'b0;
                end
                if (cnt_q == CNT_LAST) begin
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Unconditional return so the finishing request cannot retrigger.
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            base_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb/tb_sram_mem_stage.sv - directed table-driven bench for sram_mem_stage
module tb_sram_mem_stage;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [15:0] mem    [256];
    int          we_cnt [256];

    int checks;
    int errors;

    sram_mem_stage #(
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(2),
        .SRAM_AW    (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    assign sram_dq_in = mem[sram_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          perturb;
        bit          pre_en;
        logic [7:0]  pre_idx;
        logic [15:0] pre_lo;
        logic [15:0] pre_hi;
        logic [31:0] exp_rd;
        int          exp_wl;
        bit          chk_mem;
        logic [7:0]  mem_idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Mid-cycle: the SRAM model commits a strobed write, outputs are sampled after it.
    task automatic half();
        @(negedge clk);
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]]    = sram_dq_out;
            we_cnt[sram_addr[7:0]] = we_cnt[sram_addr[7:0]] + 1;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int          rl;
        int          wl;
        bit          done;
        logic [31:0] rd;
        rl   = 0;
        wl   = 0;
        done = 1'b0;
        rd   = 32'h0;
        if (v.pre_en) begin
            mem[v.pre_idx]        = v.pre_lo;
            mem[v.pre_idx + 8'd1] = v.pre_hi;
        end
        wr_en      = v.wr;
        rd_en      = v.rd;
        address    = v.addr;
        write_data = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (v.perturb && c == 1) begin
                address    = 32'h0000_0000;
                write_data = 32'hFFFF_FFFF;
            end
            half();
            if (!sram_we_n) wl++;
            if (ready) begin
                done = 1'b1;
                rd   = read_data;
            end else begin
                rl++;
            end
            next();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done required=done", tag);
        end else begin
            chk({tag, " read_data"}, rd, v.exp_rd);
            chk({tag, " ready_low"}, rl, 5);
            chk({tag, " we_low"}, wl, v.exp_wl);
            if (v.chk_mem) begin
                chk({tag, " mem_lo"}, {16'h0, mem[v.mem_idx]}, {16'h0, v.exp_lo});
                chk({tag, " mem_hi"}, {16'h0, mem[v.mem_idx + 8'd1]}, {16'h0, v.exp_hi});
            end
        end
    endtask

    initial begin
        vec_t ld;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'h0000;
            we_cnt[i] = 0;
        end
        // wr rd addr wdata perturb pre_en pre_idx pre_lo pre_hi exp_rd exp_wl chk_mem mem_idx exp_lo exp_hi
        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'h0000_0000, 4, 1'b1, 8'd0, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b1, 8'd6, 16'h0029, 16'h0000,
                    32'h0000_0029, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        vecs[2] = '{1'b0, 1'b1, 32'd1038, 32'h0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'h0000_0029, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        vecs[3] = '{1'b1, 1'b1, 32'd1028, 32'hC0000000, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'h0000_0029, 4, 1'b1, 8'd2, 16'h0000, 16'hC000};
        vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'hC000_0000, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        vecs[5] = '{1'b1, 1'b0, 32'd1044, 32'h12345678, 1'b1, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'hC000_0000, 4, 1'b1, 8'd10, 16'h5678, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 32'd1044, 32'h0, 1'b1, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'h1234_5678, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        vecs[7] = '{1'b0, 1'b1, 32'h0008_0400, 32'h0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
                    32'hDEAD_BEEF, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        vecs[8] = '{1'b0, 1'b1, 32'd1020, 32'h0, 1'b0, 1'b1, 8'hFE, 16'h1111, 16'h2222,
                    32'h2222_1111, 0, 1'b0, 8'd0, 16'h0, 16'h0};

        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            half();
            chk("idle ready", {31'h0, ready}, 32'h1);
            chk("idle we_n", {31'h0, sram_we_n}, 32'h1);
            chk("idle oe", {31'h0, sram_dq_oe}, 32'h0);
            chk("idle read_data", read_data, 32'h0);
            chk("idle sram_addr", {14'h0, sram_addr}, 32'h0);
            next();
        end

        // Back-to-back: each vector is issued the cycle after the previous DONE.
        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i], $sformatf("v%0d", i));
        end

        // Store to 1040 interrupted by reset in the first HIGH cycle.
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hAAAA5555;
        repeat (3) begin
            half();
            next();
        end
        half();
        chk("rst high addr", {14'h0, sram_addr}, 32'd9);
        chk("rst high we_n", {31'h0, sram_we_n}, 32'h0);
        rst   = 1'b1;
        wr_en = 1'b0;
        next();
        half();
        chk("rst we_n", {31'h0, sram_we_n}, 32'h1);
        chk("rst oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("rst ready", {31'h0, ready}, 32'h1);
        chk("rst read_data", read_data, 32'h0);
        rst = 1'b0;
        next();
        chk("rst mem8", {16'h0, mem[8]}, 32'h0000_5555);
        chk("rst we_cnt8", we_cnt[8], 2);
        chk("rst we_cnt9", we_cnt[9], 1);

        ld = '{1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0, 8'd0, 16'h0, 16'h0,
               32'hDEAD_BEEF, 0, 1'b0, 8'd0, 16'h0, 16'h0};
        run_req(ld, "post_rst load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
